// File: rtl/bsg_and_reduce_serial_if.sv
// bsg_and_reduce_serial_if: word stream in, reduced mask out, with valid/ready and valid/yumi handshakes
interface bsg_and_reduce_serial_if #(
  parameter int width_p = 16,
  parameter int els_p   = 4
);
  localparam int lg_els_lp = $clog2(els_p + 1);
  logic                 v_i;
  logic [width_p-1:0]   data_i;
  logic                 last_i;
  logic                 ready_o;
  logic                 v_o;
  logic [width_p-1:0]   data_o;
  logic [lg_els_lp-1:0] count_o;
  logic                 yumi_i;
  modport master (
    output v_i, data_i, last_i, yumi_i,
    input  ready_o, v_o, data_o, count_o
  );
  modport slave (
    input  v_i, data_i, last_i, yumi_i,
    output ready_o, v_o, data_o, count_o
  );
endinterface

// File: rtl/bsg_and_reduce_serial.sv
// bsg_and_reduce_serial: folds a serial group of up to els_p words into their bitwise AND
module bsg_and_reduce_serial #(
  parameter int width_p = 16,
  parameter int els_p   = 4
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  bsg_and_reduce_serial_if.slave io
);
  localparam int lg_els_lp = $clog2(els_p + 1);
  localparam logic [lg_els_lp-1:0] last_cnt_lp = lg_els_lp'(els_p - 1);
  typedef enum logic {ACCUM, DONE} state_e;
  state_e               state_q, state_d;
  logic [width_p-1:0]   acc_q, acc_d;
  logic [lg_els_lp-1:0] count_q, count_d;
  logic                 hs, close;
  assign hs    = io.v_i & (state_q == ACCUM);
  assign close = io.last_i | (count_q == last_cnt_lp);
  // fold accepted words while collecting; clear back to all ones once the result is taken
  always_comb begin
    state_d = (state_q == ACCUM) ? ((hs && close) ? DONE : ACCUM) : (io.yumi_i ? ACCUM : DONE);
    acc_d   = (state_q == ACCUM) ? (hs ? acc_q & io.data_i : acc_q) : (io.yumi_i ? '1 : acc_q);
    count_d = (state_q == ACCUM) ? (hs ? count_q + 1'b1 : count_q) : (io.yumi_i ? '0 : count_q);
  end
  // state registers; reset drops any partial group
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ACCUM;
      acc_q   <= '1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end
  assign io.ready_o = (state_q == ACCUM);
  assign io.v_o     = (state_q == DONE);
  assign io.data_o  = acc_q;
  assign io.count_o = count_q;
endmodule

// File: tb/tb_bsg_and_reduce_serial.sv
// tb_bsg_and_reduce_serial: scoreboard bench for the serial AND reducer
module tb_bsg_and_reduce_serial;
  typedef struct {logic [15:0] d; logic [2:0] c;} res_t;
  logic clk_i = 0;
  logic reset_n_i = 0;
  int checks = 0;
  int failures = 0;
  res_t q[$];
  logic [15:0] m_acc = '1;
  logic [2:0]  m_cnt = 0;
  bsg_and_reduce_serial_if #(.width_p(16), .els_p(4)) b ();
  bsg_and_reduce_serial #(.width_p(16), .els_p(4)) dut (.clk_i(clk_i), .reset_n_i(reset_n_i), .io(b));
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) if (reset_n_i) assert (!(b.yumi_i && !b.v_o)) else $error("FAIL yumi_in_accum");
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_acc = '1;
    m_cnt = 0;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    b.v_i = 1;
    b.data_i = d;
    b.last_i = l;
    while (b.ready_o !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
    checks++;
    if (b.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL send_ready got=%b exp=1", b.ready_o);
    end else begin
      @(negedge clk_i);
      m_acc = m_acc & d;
      m_cnt++;
      if (l || m_cnt == 4) begin q.push_back('{m_acc, m_cnt}); model_clear(); end
    end
  endtask

  task automatic idle(input int n);
    b.v_i = 0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic take();
    res_t e;
    int n = 0;
    while (b.v_o !== 1'b1 && n < 50) begin @(negedge clk_i); n++; end
    checks++;
    if (b.v_o !== 1'b1 || q.size() == 0) begin
      failures++;
      $display("FAIL take_valid v_o=%b queued=%0d exp v_o=1 queued>0", b.v_o, q.size());
    end else begin
      e = q.pop_front();
      if (b.data_o !== e.d) begin failures++; $display("FAIL take_data got=%h exp=%h", b.data_o, e.d); end
      checks++;
      if (b.count_o !== e.c) begin failures++; $display("FAIL take_count got=%0d exp=%0d", b.count_o, e.c); end
      b.yumi_i = 1;
      @(negedge clk_i);
      b.yumi_i = 0;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (b.ready_o !== 1'b1 || b.v_o !== 1'b0 || b.data_o !== 16'hFFFF || b.count_o !== 3'd0) begin
      failures++;
      $display("FAIL %s got ready=%b v=%b data=%h count=%0d exp ready=1 v=0 data=ffff count=0",
               name, b.ready_o, b.v_o, b.data_o, b.count_o);
    end
  endtask

  task automatic test_reset();
    b.v_i = 0; b.data_i = 0; b.last_i = 0; b.yumi_i = 0;
    reset_n_i = 0;
    repeat (3) @(negedge clk_i);
    check_idle_outputs("reset_outputs");
    reset_n_i = 1;
    model_clear();
    q.delete();
    @(negedge clk_i);
    check_idle_outputs("after_reset_idle");
  endtask

  task automatic test_full_group();
    send(16'hFFF0, 0);
    send(16'h0FFF, 0);
    send(16'hF0FF, 0);
    send(16'hFF0F, 0);
    b.v_i = 0;
    checks++;
    if (b.v_o !== 1'b1 || b.ready_o !== 1'b0 || b.data_o !== 16'h0000 || b.count_o !== 3'd4) begin
      failures++;
      $display("FAIL full_group got v=%b ready=%b data=%h count=%0d exp v=1 ready=0 data=0000 count=4",
               b.v_o, b.ready_o, b.data_o, b.count_o);
    end
    repeat (2) @(negedge clk_i);
    checks++;
    if (b.ready_o !== 1'b0) begin failures++; $display("FAIL full_hold_ready got=%b exp=0", b.ready_o); end
    take();
  endtask

  task automatic test_early_term();
    send(16'hA5A5, 0);
    send(16'hFFFF, 1);
    b.v_i = 0;
    checks++;
    if (b.data_o !== 16'hA5A5 || b.count_o !== 3'd2) begin
      failures++;
      $display("FAIL early_term got data=%h count=%0d exp data=a5a5 count=2", b.data_o, b.count_o);
    end
    take();
    send(16'h00FF, 1);
    b.v_i = 0;
    checks++;
    if (b.data_o !== 16'h00FF || b.count_o !== 3'd1) begin
      failures++;
      $display("FAIL single_word got data=%h count=%0d exp data=00ff count=1", b.data_o, b.count_o);
    end
    take();
  endtask

  task automatic test_backpressure();
    send(16'h0F0F, 1);
    b.v_i = 1; b.data_i = 16'h1234; b.last_i = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      checks++;
      if (b.ready_o !== 1'b0 || b.v_o !== 1'b1 || b.data_o !== 16'h0F0F || b.count_o !== 3'd1) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d got ready=%b v=%b data=%h count=%0d exp ready=0 v=1 data=0f0f count=1",
                 i, b.ready_o, b.v_o, b.data_o, b.count_o);
      end
    end
    take();
    checks++;
    if (b.ready_o !== 1'b1 || b.count_o !== 3'd0) begin
      failures++;
      $display("FAIL after_yumi got ready=%b count=%0d exp ready=1 count=0", b.ready_o, b.count_o);
    end
    send(16'h1234, 1);
    b.v_i = 0;
    take();
  endtask

  task automatic test_bubbles();
    send(16'hF00F, 0);
    idle(3);
    checks++;
    if (b.count_o !== 3'd1) begin failures++; $display("FAIL bubble_count got=%0d exp=1", b.count_o); end
    send(16'hFF00, 0);
    idle(1);
    send(16'h0FF0, 0);
    send(16'h00FF, 0);
    b.v_i = 0;
    checks++;
    if (b.data_o !== 16'h0000 || b.count_o !== 3'd4 || b.v_o !== 1'b1) begin
      failures++;
      $display("FAIL bubbles got v=%b data=%h count=%0d exp v=1 data=0000 count=4", b.v_o, b.data_o, b.count_o);
    end
    take();
  endtask

  task automatic test_async_reset();
    send(16'h1111, 0);
    send(16'h3333, 0);
    b.v_i = 0;
    #2 reset_n_i = 0;
    #1 check_idle_outputs("async_reset");
    #1 reset_n_i = 1;
    model_clear();
    @(negedge clk_i);
    check_idle_outputs("async_reset_released");
    for (int i = 0; i < 4; i++) send(16'h8001, 0);
    b.v_i = 0;
    checks++;
    if (b.data_o !== 16'h8001 || b.count_o !== 3'd4) begin
      failures++;
      $display("FAIL post_reset_group got data=%h count=%0d exp data=8001 count=4", b.data_o, b.count_o);
    end
    take();
  endtask

  task automatic test_random();
    int sent = 0, got = 0, cyc = 0, widx = 0, glen = 1;
    logic pending = 0;
    logic [15:0] pd = 0;
    logic pl = 0;
    res_t e;
    while ((got < 1000 || q.size() != 0) && cyc < 30000) begin
      cyc++;
      b.yumi_i = 0;
      if (b.v_o === 1'b1 && $urandom_range(0, 2) != 0) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra_result data=%h count=%0d exp none", b.data_o, b.count_o);
        end else begin
          e = q.pop_front();
          if (b.data_o !== e.d || b.count_o !== e.c) begin
            failures++;
            $display("FAIL rand_result got data=%h count=%0d exp data=%h count=%0d", b.data_o, b.count_o, e.d, e.c);
          end
        end
        b.yumi_i = 1;
        got++;
      end
      if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
        if (widx == 0) glen = $urandom_range(1, 4);
        pd = 16'($urandom | $urandom);
        pl = (widx + 1 == glen) && (glen < 4 || $urandom_range(0, 1) == 1);
        pending = 1;
      end
      b.v_i = pending;
      b.data_i = pd;
      b.last_i = pl;
      if (pending && b.ready_o === 1'b1) begin
        pending = 0;
        m_acc = m_acc & pd;
        m_cnt++;
        widx++;
        if (pl || m_cnt == 4) begin
          q.push_back('{m_acc, m_cnt});
          model_clear();
          widx = 0;
          sent++;
        end
      end
      @(negedge clk_i);
    end
    b.v_i = 0;
    b.yumi_i = 0;
    checks++;
    if (got != 1000 || q.size() != 0) begin
      failures++;
      $display("FAIL rand_totals got=%0d left=%0d exp got=1000 left=0", got, q.size());
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_full_group();
    test_early_term();
    test_backpressure();
    test_bubbles();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
